// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared opcodes, ALU operation encoding and FSM state type
//                for the RV32I multicycle controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // RV32I major opcodes handled by the controller
    localparam logic [6:0] C_OP_R   = 7'b0110011;
    localparam logic [6:0] C_OP_I   = 7'b0010011;
    localparam logic [6:0] C_OP_LW  = 7'b0000011;
    localparam logic [6:0] C_OP_SW  = 7'b0100011;
    localparam logic [6:0] C_OP_BEQ = 7'b1100011;

    // ALU operation encoding shared with the datapath
    localparam logic [3:0] C_ALU_AND = 4'b0000;
    localparam logic [3:0] C_ALU_OR  = 4'b0001;
    localparam logic [3:0] C_ALU_ADD = 4'b0010;
    localparam logic [3:0] C_ALU_XOR = 4'b0101;
    localparam logic [3:0] C_ALU_SUB = 4'b0110;
    localparam logic [3:0] C_ALU_SLT = 4'b0111;
    localparam logic [3:0] C_ALU_SLL = 4'b1000;
    localparam logic [3:0] C_ALU_SRL = 4'b1001;
    localparam logic [3:0] C_ALU_SRA = 4'b1010;

    // Controller states
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder
//  Description : Maps opcode/funct3/funct7[5] to the ALU operation and flags
//                any encoding the controller does not support.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_b5,
    output logic [3:0] o_alu_ctrl,
    output logic       o_illegal
);

    // Pure decode table; funct7[5] selects SUB only for R-type, SRA for both
    always_comb begin
        o_alu_ctrl = C_ALU_ADD;
        o_illegal  = 1'b0;
        case (i_opcode)
            C_OP_R, C_OP_I: begin
                case (i_funct3)
                    3'b000:  o_alu_ctrl = ((i_opcode == C_OP_R) && i_funct7_b5) ? C_ALU_SUB : C_ALU_ADD;
                    3'b001:  o_alu_ctrl = C_ALU_SLL;
                    3'b010:  o_alu_ctrl = C_ALU_SLT;
                    3'b100:  o_alu_ctrl = C_ALU_XOR;
                    3'b101:  o_alu_ctrl = i_funct7_b5 ? C_ALU_SRA : C_ALU_SRL;
                    3'b110:  o_alu_ctrl = C_ALU_OR;
                    3'b111:  o_alu_ctrl = C_ALU_AND;
                    default: o_illegal  = 1'b1;   // SLTU/SLTIU not supported
                endcase
            end
            C_OP_LW, C_OP_SW: o_alu_ctrl = C_ALU_ADD;
            C_OP_BEQ: begin
                o_alu_ctrl = C_ALU_SUB;
                o_illegal  = (i_funct3 != 3'b000);
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Multicycle control FSM for an RV32I subset datapath
//                (R, I-ALU, LW, SW, BEQ) with separate imem/dmem handshakes,
//                halt at instruction boundaries and a sticky illegal trap.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int RET_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             PCSrc,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic [3:0]       ALUCtrl,
    output logic             loadPC,
    input  logic             halt_req,
    output logic             halted,
    output logic             trap,
    output logic [RET_W-1:0] retired
);

    state_t           r_state;
    state_t           w_next;
    logic [RET_W-1:0] r_retired;

    logic [6:0] w_opcode;
    logic [3:0] w_dec_alu;
    logic       w_illegal;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_beq;
    logic       w_use_imm;

    logic       w_imem_req, w_ir_load, w_dmem_req, w_dmem_we, w_pc_src;
    logic       w_alu_src, w_reg_write, w_mem_to_reg, w_load_pc, w_halted, w_trap;
    logic [3:0] w_alu_ctrl;

    assign w_opcode  = instr[6:0];
    assign w_is_lw   = (w_opcode == C_OP_LW);
    assign w_is_sw   = (w_opcode == C_OP_SW);
    assign w_is_beq  = (w_opcode == C_OP_BEQ);
    assign w_use_imm = (w_opcode == C_OP_I) || w_is_lw || w_is_sw;

    // instr[30] is funct7[5] for R-type and the SRAI select bit for I-type
    alu_decoder u_alu_decoder (
        .i_opcode    (w_opcode),
        .i_funct3    (instr[14:12]),
        .i_funct7_b5 (instr[30]),
        .o_alu_ctrl  (w_dec_alu),
        .o_illegal   (w_illegal)
    );

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    // Retired-instruction counter, bumped on the PC-update strobe, wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            r_retired <= '0;
        else if (w_load_pc) r_retired <= r_retired + 1'b1;
    end

    // Next-state and control outputs from current state and held IR
    always_comb begin
        w_next       = r_state;
        w_imem_req   = 1'b0;
        w_ir_load    = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_pc_src     = 1'b0;
        w_alu_src    = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_ctrl   = 4'b0000;
        w_load_pc    = 1'b0;
        w_halted     = 1'b0;
        w_trap       = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (halt_req) begin
                    w_next = S_HALT;
                end else begin
                    w_imem_req = 1'b1;
                    if (imem_ack) begin
                        w_ir_load = 1'b1;
                        w_next    = S_DECODE;
                    end
                end
            end
            S_DECODE: w_next = w_illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                w_alu_src  = w_use_imm;
                w_alu_ctrl = w_dec_alu;
                if (w_is_beq) begin
                    w_load_pc = 1'b1;
                    w_pc_src  = zero;
                    w_next    = S_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                // ALU controls held so the address stays stable across waits
                w_alu_src  = w_use_imm;
                w_alu_ctrl = w_dec_alu;
                w_dmem_req = 1'b1;
                w_dmem_we  = w_is_sw;
                if (dmem_ack) begin
                    w_reg_write  = w_is_lw;
                    w_mem_to_reg = w_is_lw;
                    w_load_pc    = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_WB: begin
                w_alu_src   = w_use_imm;
                w_alu_ctrl  = w_dec_alu;
                w_reg_write = 1'b1;
                w_load_pc   = 1'b1;
                w_next      = S_FETCH;
            end
            S_HALT: begin
                w_halted = 1'b1;
                if (!halt_req) w_next = S_FETCH;
            end
            S_TRAP:  w_trap = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    // Outputs forced low while reset is asserted
    assign imem_req = w_imem_req   & ~rst;
    assign ir_load  = w_ir_load    & ~rst;
    assign dmem_req = w_dmem_req   & ~rst;
    assign dmem_we  = w_dmem_we    & ~rst;
    assign PCSrc    = w_pc_src     & ~rst;
    assign ALUSrc   = w_alu_src    & ~rst;
    assign RegWrite = w_reg_write  & ~rst;
    assign MemtoReg = w_mem_to_reg & ~rst;
    assign ALUCtrl  = rst ? 4'b0000 : w_alu_ctrl;
    assign loadPC   = w_load_pc    & ~rst;
    assign halted   = w_halted     & ~rst;
    assign trap     = w_trap       & ~rst;
    assign retired  = r_retired;

endmodule
`default_nettype wire
